// File: rtl/best_neighbor_scan_pkg.sv
// Shared constants for the neighbour-table scanner: default widths, entry layout,
// invalid-Q marker and the scan FSM state encoding.
package best_neighbor_scan_pkg;

  localparam int DFLT_WORD_WIDTH    = 16;
  localparam int DFLT_ADDR_WIDTH    = 11;
  localparam int DFLT_MAX_NEIGHBORS = 64;

  // Each table entry occupies three consecutive words.
  localparam int OFS_ID      = 0;
  localparam int OFS_Q       = 1;
  localparam int OFS_HOP     = 2;
  localparam int ENTRY_WORDS = 3;

  localparam logic [15:0] INVALID_Q = 16'hFFFF;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_RD_ID  = 3'd1,
    ST_RD_Q   = 3'd2,
    ST_RD_HOP = 3'd3,
    ST_CMP    = 3'd4,
    ST_DONE   = 3'd5
  } state_t;

endpackage

// File: rtl/best_neighbor_scan_entry_compare.sv
// Decides whether a candidate entry displaces the current best one.
// Build macro HOP_TIEBREAK_EN: equal Q with a strictly smaller hop also wins.
module entry_compare #(
  parameter int W = 16
) (
  input  logic [W-1:0] cand_q_i,
  input  logic [W-1:0] cand_hop_i,
  input  logic [W-1:0] best_q_i,
  input  logic [W-1:0] best_hop_i,
  output logic         replace_o
);

`ifdef HOP_TIEBREAK_EN
  localparam bit TIE_EN = 1'b1;
`else
  localparam bit TIE_EN = 1'b0;
`endif

  localparam logic [W-1:0] INVALID_W = '1;

  logic cand_valid;
  logic q_lt;
  logic q_eq;
  logic hop_lt;

  // An all-ones Q marks an unused slot and must never win, even on a tie.
  assign cand_valid = (cand_q_i != INVALID_W);
  assign q_lt       = (cand_q_i < best_q_i);
  assign q_eq       = (cand_q_i == best_q_i);
  assign hop_lt     = (cand_hop_i < best_hop_i);

  assign replace_o = cand_valid && (q_lt || (TIE_EN && q_eq && hop_lt));

endmodule

// File: rtl/best_neighbor_scan.sv
// Walks a neighbour table in memory (ID, Q, hop per entry) and reports the entry
// with the lowest Q plus how many beat our own Q. Build macro: HOP_TIEBREAK_EN.
module best_neighbor_scan
  import best_neighbor_scan_pkg::*;
#(
  parameter int WORD_WIDTH    = DFLT_WORD_WIDTH,
  parameter int ADDR_WIDTH    = DFLT_ADDR_WIDTH,
  parameter int MAX_NEIGHBORS = DFLT_MAX_NEIGHBORS
) (
  input  logic                  clock,
  input  logic                  rst,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] table_base,
  input  logic [WORD_WIDTH-1:0] neighbor_count,
  input  logic [WORD_WIDTH-1:0] mybest,
  output logic [ADDR_WIDTH-1:0] address,
  input  logic [WORD_WIDTH-1:0] mem_data_out,
  output logic [WORD_WIDTH-1:0] bestvalue,
  output logic [WORD_WIDTH-1:0] bestneighborID,
  output logic [WORD_WIDTH-1:0] besthop,
  output logic [WORD_WIDTH-1:0] betterNeighborCount,
  output logic                  busy,
  output logic                  done
);

  localparam logic [WORD_WIDTH-1:0] RESULT_INIT = '1;
  localparam logic [WORD_WIDTH-1:0] MAX_N_W     = WORD_WIDTH'(MAX_NEIGHBORS);

  state_t                state_q;
  logic [ADDR_WIDTH-1:0] address_q;
  logic [ADDR_WIDTH-1:0] ent_base_q;
  logic [WORD_WIDTH-1:0] n_q;
  logic [WORD_WIDTH-1:0] idx_q;
  logic [WORD_WIDTH-1:0] mybest_q;
  logic [WORD_WIDTH-1:0] id_q;
  logic [WORD_WIDTH-1:0] qv_q;
  logic [WORD_WIDTH-1:0] bestvalue_q;
  logic [WORD_WIDTH-1:0] bestid_q;
  logic [WORD_WIDTH-1:0] besthop_q;
  logic [WORD_WIDTH-1:0] better_q;
  logic                  busy_q;
  logic                  done_q;

  logic [WORD_WIDTH-1:0] n_clamped;
  logic [WORD_WIDTH-1:0] idx_d;
  logic [ADDR_WIDTH-1:0] ent_base_d;
  logic                  replace;
  logic                  better;

  assign n_clamped  = (neighbor_count > MAX_N_W) ? MAX_N_W : neighbor_count;
  assign idx_d      = idx_q + WORD_WIDTH'(1);
  assign ent_base_d = ent_base_q + ADDR_WIDTH'(ENTRY_WORDS);

  // In CMP the hop word is on the memory bus right now; Q was captured a cycle earlier.
  entry_compare #(
    .W (WORD_WIDTH)
  ) u_cmp (
    .cand_q_i   (qv_q),
    .cand_hop_i (mem_data_out),
    .best_q_i   (bestvalue_q),
    .best_hop_i (besthop_q),
    .replace_o  (replace)
  );

  assign better = (qv_q < mybest_q) && (qv_q != RESULT_INIT);

  always_ff @(posedge clock) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      address_q   <= '0;
      ent_base_q  <= '0;
      n_q         <= '0;
      idx_q       <= '0;
      mybest_q    <= '0;
      id_q        <= '0;
      qv_q        <= '0;
      bestvalue_q <= RESULT_INIT;
      bestid_q    <= RESULT_INIT;
      besthop_q   <= RESULT_INIT;
      better_q    <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            mybest_q    <= mybest;
            n_q         <= n_clamped;
            idx_q       <= '0;
            bestvalue_q <= RESULT_INIT;
            bestid_q    <= RESULT_INIT;
            besthop_q   <= RESULT_INIT;
            better_q    <= '0;
            busy_q      <= 1'b1;
            if (n_clamped == '0) begin
              state_q <= ST_DONE;
              done_q  <= 1'b1;
            end else begin
              state_q    <= ST_RD_ID;
              ent_base_q <= table_base;
              address_q  <= table_base + ADDR_WIDTH'(OFS_ID);
            end
          end
        end
        ST_RD_ID: begin
          state_q   <= ST_RD_Q;
          address_q <= ent_base_q + ADDR_WIDTH'(OFS_Q);
        end
        ST_RD_Q: begin
          id_q      <= mem_data_out;
          state_q   <= ST_RD_HOP;
          address_q <= ent_base_q + ADDR_WIDTH'(OFS_HOP);
        end
        ST_RD_HOP: begin
          qv_q    <= mem_data_out;
          state_q <= ST_CMP;
        end
        ST_CMP: begin
          if (replace) begin
            bestvalue_q <= qv_q;
            bestid_q    <= id_q;
            besthop_q   <= mem_data_out;
          end
          if (better) begin
            better_q <= better_q + WORD_WIDTH'(1);
          end
          if (idx_d == n_q) begin
            state_q <= ST_DONE;
            done_q  <= 1'b1;
          end else begin
            idx_q      <= idx_d;
            ent_base_q <= ent_base_d;
            address_q  <= ent_base_d + ADDR_WIDTH'(OFS_ID);
            state_q    <= ST_RD_ID;
          end
        end
        ST_DONE: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign address             = address_q;
  assign bestvalue           = bestvalue_q;
  assign bestneighborID      = bestid_q;
  assign besthop             = besthop_q;
  assign betterNeighborCount = better_q;
  assign busy                = busy_q;
  assign done                = done_q;

endmodule

// File: tb/tb_best_neighbor_scan.sv
// Scoreboard bench for best_neighbor_scan: scans push expected results, a monitor
// checks them on each done pulse together with the start-to-done latency.
module tb_best_neighbor_scan;

  logic        clock = 1'b0;
  logic        rst;
  logic        start;
  logic [10:0] table_base;
  logic [15:0] neighbor_count;
  logic [15:0] mybest;
  logic [10:0] address;
  logic [15:0] mem_data_out;
  logic [15:0] bestvalue;
  logic [15:0] bestneighborID;
  logic [15:0] besthop;
  logic [15:0] betterNeighborCount;
  logic        busy;
  logic        done;

  always #5 clock = ~clock;

  best_neighbor_scan dut (
    .clock               (clock),
    .rst                 (rst),
    .start               (start),
    .table_base          (table_base),
    .neighbor_count      (neighbor_count),
    .mybest              (mybest),
    .address             (address),
    .mem_data_out        (mem_data_out),
    .bestvalue           (bestvalue),
    .bestneighborID      (bestneighborID),
    .besthop             (besthop),
    .betterNeighborCount (betterNeighborCount),
    .busy                (busy),
    .done                (done)
  );

  logic [15:0] mem [0:2047];
  always @(posedge clock) mem_data_out <= mem[address];

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  typedef struct {
    string       name;
    logic [15:0] bv;
    logic [15:0] id;
    logic [15:0] hop;
    logic [15:0] cnt;
    int          lat;
    int          start_cyc;
  } exp_t;

  exp_t sb[$];
  int   n_chk  = 0;
  int   n_fail = 0;

  task automatic chk(input string nm, input longint act, input longint exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end else begin
      $display("ok   %s: %0d", nm, act);
    end
  endtask

  // Monitor: every done pulse must match the oldest outstanding expectation.
  exp_t cur;
  always @(negedge clock) begin
    if (done) begin
      if (sb.size() == 0) begin
        chk("unexpected_done", 1, 0);
      end else begin
        cur = sb.pop_front();
        chk({cur.name, "_bestvalue"}, bestvalue, cur.bv);
        chk({cur.name, "_bestneighborID"}, bestneighborID, cur.id);
        chk({cur.name, "_besthop"}, besthop, cur.hop);
        chk({cur.name, "_betterCount"}, betterNeighborCount, cur.cnt);
        chk({cur.name, "_latency"}, cyc - cur.start_cyc, cur.lat);
      end
    end
  end

  // Address logger: distinct consecutive addresses seen while busy.
  logic        log_en = 1'b0;
  logic [10:0] addr_log[$];
  always @(negedge clock) begin
    if (log_en && busy && (addr_log.size() == 0 || addr_log[$] != address))
      addr_log.push_back(address);
  end

  task automatic start_scan(input string nm, input logic [10:0] base, input logic [15:0] n,
                            input logic [15:0] mb, input logic [15:0] bv, input logic [15:0] id,
                            input logic [15:0] hop, input logic [15:0] cnt, input int lat);
    exp_t e;
    e.name = nm; e.bv = bv; e.id = id; e.hop = hop; e.cnt = cnt; e.lat = lat;
    e.start_cyc = cyc + 1;
    sb.push_back(e);
    table_base     = base;
    neighbor_count = n;
    mybest         = mb;
    start          = 1'b1;
    @(negedge clock);
    start = 1'b0;
  endtask

  task automatic wait_done(input string nm, input int budget);
    bit got = 1'b0;
    for (int k = 0; k < budget; k++) begin
      if (done) begin
        got = 1'b1;
        break;
      end
      @(negedge clock);
    end
    if (!got) begin
      chk({nm, "_timeout"}, 0, 1);
      sb.delete();
    end else begin
      @(negedge clock);
      chk({nm, "_done_one_cycle"}, done, 0);
      chk({nm, "_busy_after"}, busy, 0);
    end
  endtask

  task automatic run_scan(input string nm, input logic [10:0] base, input logic [15:0] n,
                          input logic [15:0] mb, input logic [15:0] bv, input logic [15:0] id,
                          input logic [15:0] hop, input logic [15:0] cnt, input int lat);
    start_scan(nm, base, n, mb, bv, id, hop, cnt, lat);
    wait_done(nm, 400);
  endtask

  logic [10:0] wrap_exp [6] = '{11'd2046, 11'd2047, 11'd0, 11'd1, 11'd2, 11'd3};
  logic [10:0] a0;

  initial begin
    rst = 1'b1; start = 1'b0; table_base = '0; neighbor_count = '0; mybest = '0;
    for (int i = 0; i < 2048; i++) mem[i] = 16'h0;
    // basic table
    mem[100] = 4; mem[101] = 9; mem[102] = 2;
    mem[103] = 7; mem[104] = 3; mem[105] = 5;
    mem[106] = 2; mem[107] = 6; mem[108] = 1;
    // equal-Q table
    mem[200] = 4; mem[201] = 5; mem[202] = 3;
    mem[203] = 6; mem[204] = 5; mem[205] = 1;
    // table straddling the top of memory
    mem[2046] = 10; mem[2047] = 20; mem[0] = 30;
    mem[1]    = 11; mem[2]    = 15; mem[3] = 1;
    // invalid-only table
    mem[800] = 1; mem[801] = 16'hFFFF; mem[802] = 0;
    mem[803] = 2; mem[804] = 16'hFFFF; mem[805] = 0;
    // long table: Q falls with index, so scanning past 64 entries would change the winner
    for (int i = 0; i < 100; i++) begin
      mem[400 + 3*i]     = 16'(1000 + i);
      mem[400 + 3*i + 1] = 16'(500 - i);
      mem[400 + 3*i + 2] = 16'(i);
    end

    repeat (3) @(negedge clock);
    chk("reset_address", address, 0);
    chk("reset_busy", busy, 0);
    chk("reset_done", done, 0);
    chk("reset_bestvalue", bestvalue, 16'hFFFF);
    chk("reset_bestneighborID", bestneighborID, 16'hFFFF);
    chk("reset_besthop", besthop, 16'hFFFF);
    chk("reset_betterCount", betterNeighborCount, 0);
    rst = 1'b0;
    @(negedge clock);

    run_scan("basic", 11'd100, 16'd3, 16'd7, 16'd3, 16'd7, 16'd5, 16'd2, 12);

`ifdef HOP_TIEBREAK_EN
    run_scan("tie", 11'd200, 16'd2, 16'd10, 16'd5, 16'd6, 16'd1, 16'd2, 8);
`else
    run_scan("tie", 11'd200, 16'd2, 16'd10, 16'd5, 16'd4, 16'd3, 16'd2, 8);
`endif

    a0 = address;
    run_scan("empty", 11'd300, 16'd0, 16'd5, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'd0, 0);
    chk("empty_no_read_address", address, a0);

    addr_log.delete();
    log_en = 1'b1;
    run_scan("wrap", 11'd2046, 16'd2, 16'd16, 16'd15, 16'd11, 16'd1, 16'd1, 8);
    log_en = 1'b0;
    chk("wrap_addr_count", addr_log.size(), 6);
    for (int i = 0; i < 6; i++)
      chk($sformatf("wrap_addr%0d", i), (i < addr_log.size()) ? longint'(addr_log[i]) : -1,
          wrap_exp[i]);

    run_scan("invalid", 11'd800, 16'd2, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'd0, 8);

    // abort a scan with reset after its first entry has been compared
    table_base = 11'd100; neighbor_count = 16'd3; mybest = 16'd7;
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    repeat (4) @(negedge clock);
    chk("abort_midscan_bestvalue", bestvalue, 9);
    rst = 1'b1;
    @(negedge clock);
    chk("abort_address", address, 0);
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    chk("abort_bestvalue", bestvalue, 16'hFFFF);
    chk("abort_bestneighborID", bestneighborID, 16'hFFFF);
    chk("abort_besthop", besthop, 16'hFFFF);
    chk("abort_betterCount", betterNeighborCount, 0);
    rst = 1'b0;
    repeat (40) @(negedge clock);
    run_scan("after_abort", 11'd100, 16'd3, 16'd7, 16'd3, 16'd7, 16'd5, 16'd2, 12);

    // N=100 clamps to 64; a second start pulse mid-scan must be ignored
    start_scan("clamp", 11'd400, 16'd100, 16'd450, 16'd437, 16'd1063, 16'd63, 16'd13, 256);
    repeat (30) @(negedge clock);
    table_base = 11'd0; neighbor_count = 16'd1; mybest = 16'd0;
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    wait_done("clamp", 400);

    repeat (3) @(negedge clock);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
